// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage feeding the IF/ID register.
// It fetches one instruction at a time over a request/response handshake
// and holds the result until the downstream register accepts it.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   stall                    downstream hold of the presented instruction
//   redirect, redirect_pc    restart fetch at redirect_pc
//   imem_req, imem_addr      request strobe and address to instruction memory
//   imem_rvalid, imem_rdata  memory response
//   if_pc, if_instr          presented instruction (zero when if_valid=0)
//   if_valid                 presented instruction is real
// Optional macro IFETCH_PERF_EN adds perf_fetched and perf_stall_cycles
// (16-bit saturating counters).
module ifetch_unit #(
   parameter int PC_WIDTH = 12,
   parameter int INSTR_WIDTH = 12,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   redirect,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic [PC_WIDTH-1:0]    if_pc,
   output logic [INSTR_WIDTH-1:0] if_instr,
   output logic                   if_valid
`ifdef IFETCH_PERF_EN
   ,
   output logic [15:0]            perf_fetched,
   output logic [15:0]            perf_stall_cycles
`endif
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DISCARD} state_t;
   state_t state;
   logic [PC_WIDTH-1:0] pc;
   assign imem_req = state == ISSUE;
   assign imem_addr = pc;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pc <= RESET_PC;
         if_pc <= '0;
         if_instr <= '0;
         if_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= ISSUE;
               if (redirect) pc <= redirect_pc;
            end
            // the request has already left, so a redirect must still wait out its response
            ISSUE: begin
               state <= redirect ? DISCARD : WAIT;
               if (redirect) pc <= redirect_pc;
            end
            WAIT: begin
               if (redirect) begin
                  pc <= redirect_pc;
                  state <= imem_rvalid ? ISSUE : DISCARD;
               end else if (imem_rvalid) begin
                  if_pc <= pc;
                  if_instr <= imem_rdata;
                  if_valid <= 1'b1;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (redirect || !stall) begin
                  if_pc <= '0;
                  if_instr <= '0;
                  if_valid <= 1'b0;
                  pc <= redirect ? redirect_pc : pc + PC_STEP;
                  state <= ISSUE;
               end
            end
            DISCARD: begin
               if (redirect) pc <= redirect_pc;
               if (imem_rvalid) state <= ISSUE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stall_cycles <= '0;
      end else if (state == HOLD && !redirect) begin
         if (!stall && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
         if (stall && perf_stall_cycles != 16'hFFFF) perf_stall_cycles <= perf_stall_cycles + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
// A main instance (RESET_PC=0) runs against a memory model with adjustable
// latency; a second instance (RESET_PC=12'hFFF) checks PC wrap-around.
// Presented instructions are compared against a queue of expected pc/instr.
module tb_ifetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic stall = 1'b0;
   logic redirect = 1'b0;
   logic [11:0] redirect_pc = '0;
   logic imem_req;
   logic [11:0] imem_addr;
   logic imem_rvalid = 1'b0;
   logic [11:0] imem_rdata = '0;
   logic [11:0] if_pc;
   logic [11:0] if_instr;
   logic if_valid;
   logic req2;
   logic [11:0] addr2;
   logic rv2 = 1'b0;
   logic pr2 = 1'b0;
   logic [11:0] rdata2 = 12'h0B0;
   logic [11:0] rpc2 = '0;
   logic zero2 = 1'b0;
   logic [11:0] pc2;
   logic [11:0] instr2;
   logic valid2;
`ifdef IFETCH_PERF_EN
   logic [15:0] pf, ps, pf2, ps2;
`endif
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int lat = 1;
   int cnt = 0;
   logic fixed = 1'b1;
   logic [11:0] cap = '0;
   logic prev_v = 1'b0;
   logic [23:0] sb[$];
   logic [23:0] e;
   int rises[$];
   logic [11:0] a2[$];

   ifetch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid)
`ifdef IFETCH_PERF_EN
      , .perf_fetched(pf), .perf_stall_cycles(ps)
`endif
   );

   ifetch_unit #(.RESET_PC(12'hFFF)) dut2 (
      .clk(clk), .reset(reset), .stall(zero2), .redirect(zero2), .redirect_pc(rpc2),
      .imem_req(req2), .imem_addr(addr2), .imem_rvalid(rv2), .imem_rdata(rdata2),
      .if_pc(pc2), .if_instr(instr2), .if_valid(valid2)
`ifdef IFETCH_PERF_EN
      , .perf_fetched(pf2), .perf_stall_cycles(ps2)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input logic [11:0] addr, input string tag);
      int n = 0;
      @(negedge clk);
      while (!imem_req && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_seen"}, 32'(imem_req), 1);
      chk(tag, 32'(imem_addr), 32'(addr));
   endtask

   task automatic wait_pc(input logic [11:0] pc, input string tag);
      int n = 0;
      @(negedge clk);
      while (!(if_valid && if_pc == pc) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(if_valid && if_pc == pc), 1);
   endtask

   // memory model: response lat cycles after the request cycle
   always @(negedge clk) begin
      imem_rvalid = 1'b0;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = fixed ? 12'hA01 : ~cap;
         end
      end
      if (imem_req) begin
         cnt = lat;
         cap = imem_addr;
      end
   end

   // one-cycle memory for the wrap-around instance
   always @(negedge clk) begin
      rv2 = pr2;
      pr2 = req2;
      if (req2 && a2.size() < 2) a2.push_back(addr2);
   end

   // scoreboard monitor: every new instruction must match the queue head
   always @(negedge clk) begin
      cyc++;
      if (if_valid && !prev_v) begin
         chk("sb_expected", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_instr", 32'({if_pc, if_instr}), 32'(e));
         end
         rises.push_back(cyc);
      end
      if (!if_valid) chk("bubble_zero", 32'({if_pc, if_instr}), 0);
      prev_v = if_valid;
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_addr", 32'(imem_addr), 0);
      chk("rst_out", 32'({if_valid, if_pc, if_instr}), 0);
      for (int i = 0; i < 6; i++) sb.push_back({12'(i), 12'hA01});
      reset = 1'b0;
      @(negedge clk);
      chk("first_req", 32'(imem_req), 1);
      chk("first_addr", 32'(imem_addr), 0);
      wait_req(12'd1, "addr1");
      wait_req(12'd2, "addr2");
      wait_pc(12'd5, "reach_pc5");
      stall = 1'b1;
      chk("spacing01", 32'(rises[1] - rises[0]), 3);
      chk("spacing12", 32'(rises[2] - rises[1]), 3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_hold", 32'({if_valid, if_pc, if_instr}), 32'({1'b1, 12'd5, 12'hA01}));
         chk("stall_noreq", 32'(imem_req), 0);
      end
`ifdef IFETCH_PERF_EN
      chk("perf_stall4", 32'(ps), 4);
      chk("perf_fetch5", 32'(pf), 5);
`endif
      lat = 2;
      fixed = 1'b0;
      stall = 1'b0;
      @(negedge clk);
      chk("after_stall_req", 32'({imem_req, imem_addr}), 32'({1'b1, 12'd6}));
      @(negedge clk);
      chk("wait_bubble", 32'(if_valid), 0);
      redirect = 1'b1;
      redirect_pc = 12'h040;
      @(negedge clk);
      redirect = 1'b0;
      lat = 1;
      chk("discard_noreq", 32'(imem_req), 0);
      @(negedge clk);
      chk("redir_wait_req", 32'({imem_req, imem_addr}), 32'({1'b1, 12'h040}));
      sb.push_back({12'h040, 12'hFBF});
      wait_pc(12'h040, "reach_040");
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 12'h100;
      @(negedge clk);
      chk("redir_hold_clear", 32'({if_valid, if_pc, if_instr}), 0);
      chk("redir_hold_req", 32'({imem_req, imem_addr}), 32'({1'b1, 12'h100}));
`ifdef IFETCH_PERF_EN
      chk("perf_stall_redir", 32'(ps), 4);
      chk("perf_fetch_redir", 32'(pf), 6);
`endif
      redirect = 1'b0;
      stall = 1'b0;
      sb.push_back({12'h100, 12'hEFF});
      wait_pc(12'h100, "reach_100");
      @(negedge clk);
      chk("req_101", 32'({imem_req, imem_addr}), 32'({1'b1, 12'h101}));
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_req", 32'({imem_req, imem_addr}), 0);
      chk("mid_rst_out", 32'({if_valid, if_pc, if_instr}), 0);
`ifdef IFETCH_PERF_EN
      chk("mid_rst_perf", 32'({pf, ps}), 0);
`endif
      repeat (2) @(negedge clk);
      sb.push_back({12'h000, 12'hFFF});
      reset = 1'b0;
      @(negedge clk);
      chk("rerst_req", 32'({imem_req, imem_addr}), 32'({1'b1, 12'h000}));
      wait_pc(12'h000, "reach_0_again");
      chk("wrap_reqs", 32'(a2.size() >= 2), 1);
      if (a2.size() >= 2) begin
         chk("wrap_first", 32'(a2[0]), 32'(12'hFFF));
         chk("wrap_next", 32'(a2[1]), 0);
      end
      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
